// File: rtl/bridge_tx_fifo_if.sv
// bridge_tx_fifo_if: bus-side read responses in, uart_tx byte handshake out.
// Ports: data_i/rw_i/valid_i (bus), data_o/start_o/done_i (uart_tx),
//        overflow_o/fifo_count_o (status). slave = bridge, master = driver.
interface bridge_tx_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]         data_i;
    logic                          rw_i;
    logic                          valid_i;
    logic [7:0]                    data_o;
    logic                          start_o;
    logic                          done_i;
    logic                          overflow_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;

    modport slave (
        input  data_i, rw_i, valid_i, done_i,
        output data_o, start_o, overflow_o, fifo_count_o
    );

    modport master (
        output data_i, rw_i, valid_i, done_i,
        input  data_o, start_o, overflow_o, fifo_count_o
    );
endinterface

// File: rtl/bridge_tx_fifo.sv
// bridge_tx_fifo: buffers bus read responses and sends each as "D<hex>\r\n" to uart_tx.
// Ports: clk, rst (sync, active-high), bus (bridge_tx_fifo_if.slave):
//        read-response push side, uart_tx byte handshake, overflow/occupancy status.
module bridge_tx_fifo #(
    parameter int          DATA_WIDTH = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  PREAMBLE   = 8'h44
) (
    input logic            clk,
    input logic            rst,
    bridge_tx_fifo_if.slave bus
);
    localparam int ND      = DATA_WIDTH / 4;
    localparam int MSG_LEN = ND + 3;
    localparam int IW      = $clog2(MSG_LEN);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_q, wr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q;
    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  push, push_ok, pop, accept, last, empty, full;
    logic [3:0]            nib;
    logic [7:0]            hex;

    assign push    = bus.valid_i && !bus.rw_i;
    assign empty   = count_q == '0;
    assign full    = count_q == CW'(FIFO_DEPTH);
    assign accept  = state_q == SEND && bus.done_i;
    assign last    = accept && idx_q == IW'(MSG_LEN - 1);
    assign pop     = !empty && (state_q == IDLE || last);
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign count_d = count_q + CW'(push_ok) - CW'(pop);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        if (state_q == IDLE) begin
            if (!empty) begin
                state_d = SEND;
                idx_d   = '0;
                word_d  = mem[rd_q];
            end
        end else if (last) begin
            idx_d   = '0;
            state_d = empty ? IDLE : SEND;
            word_d  = empty ? word_q : mem[rd_q];
        end else if (accept) begin
            idx_d = idx_q + IW'(1);
        end
    end

    // idx k+1 selects nibble ND-1-k, so the most significant digit goes first.
    always_comb begin
        nib = '0;
        for (int k = 0; k < ND; k++)
            if (idx_q == IW'(ND - k)) nib = word_q[4*k +: 4];
    end

    assign hex = nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};

    assign bus.data_o       = idx_q == '0 ? PREAMBLE :
                              idx_q == IW'(MSG_LEN - 2) ? 8'h0D :
                              idx_q == IW'(MSG_LEN - 1) ? 8'h0A : hex;
    assign bus.start_o      = state_q == SEND;
    assign bus.overflow_o   = overflow_q;
    assign bus.fifo_count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= bus.data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            count_q <= count_d;
            if (pop) rd_q <= rd_q + AW'(1);
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (push && !push_ok) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bridge_tx_fifo.sv
// tb_bridge_tx_fifo: directed checks of bridge_tx_fifo at 16-bit and 32-bit data widths.
module tb_bridge_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_n = 0;
    int   total_n = 0;
    logic [7:0] got [$];

    always #5 clk = ~clk;

    bridge_tx_fifo_if #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) b16();
    bridge_tx_fifo_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) b32();

    bridge_tx_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .PREAMBLE(8'h44)) dut16 (
        .clk(clk), .rst(rst), .bus(b16)
    );
    bridge_tx_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PREAMBLE(8'h44)) dut32 (
        .clk(clk), .rst(rst), .bus(b32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push16(input logic [15:0] d);
        b16.valid_i = 1'b1;
        b16.rw_i    = 1'b0;
        b16.data_i  = d;
        tick();
        b16.valid_i = 1'b0;
    endtask

    // Plays uart_tx: done_i high one cycle out of every gap+1; records accepted bytes.
    task automatic recv(input bit w, input int n, input int gap, output bit cont);
        int cyc;
        int ph;
        bit started;
        logic st;
        logic [7:0] dat;
        got.delete();
        cont = 1'b1;
        started = 1'b0;
        cyc = 0;
        ph = 0;
        while (got.size() < n && cyc < 2000) begin
            if (w) b32.done_i = (ph == 0);
            else b16.done_i = (ph == 0);
            st  = w ? b32.start_o : b16.start_o;
            dat = w ? b32.data_o : b16.data_o;
            if (st && ph == 0) begin
                got.push_back(dat);
                started = 1'b1;
            end else if (started && !st) begin
                cont = 1'b0;
            end
            ph = (ph >= gap) ? 0 : ph + 1;
            tick();
            cyc++;
        end
        b16.done_i = 1'b1;
        b32.done_i = 1'b1;
        total_n++;
        if (got.size() != n) $display("FAIL recv_count: got %0d bytes, required %0d", got.size(), n);
        else pass_n++;
    endtask

    task automatic test_reset();
        do_reset();
        total_n++; if (b16.start_o !== 1'b0) $display("FAIL rst_start: %b vs 0", b16.start_o); else pass_n++;
        total_n++; if (b16.overflow_o !== 1'b0) $display("FAIL rst_ovf: %b vs 0", b16.overflow_o); else pass_n++;
        total_n++; if (b16.fifo_count_o !== 3'd0) $display("FAIL rst_count: %0d vs 0", b16.fifo_count_o); else pass_n++;
        total_n++; if (b16.data_o !== 8'h44) $display("FAIL rst_data: %h vs 44", b16.data_o); else pass_n++;
        total_n++; if (b32.data_o !== 8'h44 || b32.start_o !== 1'b0) $display("FAIL rst_32: data %h start %b vs 44 0", b32.data_o, b32.start_o); else pass_n++;
    endtask

    task automatic test_single();
        logic [7:0] exp [7] = '{8'h44, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
        bit cont;
        push16(16'h1A2F);
        total_n++; if (b16.start_o !== 1'b0 || b16.fifo_count_o !== 3'd1) $display("FAIL single_t0: start %b count %0d vs 0 1", b16.start_o, b16.fifo_count_o); else pass_n++;
        b16.done_i = 1'b0;
        tick();
        total_n++; if (b16.start_o !== 1'b1 || b16.data_o !== 8'h44 || b16.fifo_count_o !== 3'd0) $display("FAIL single_t1: start %b data %h count %0d vs 1 44 0", b16.start_o, b16.data_o, b16.fifo_count_o); else pass_n++;
        recv(1'b0, 7, 2, cont);
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            total_n++; if (got[i] !== exp[i]) $display("FAIL single_byte%0d: %h vs %h", i, got[i], exp[i]); else pass_n++;
        end
        total_n++; if (b16.start_o !== 1'b0) $display("FAIL single_end_start: %b vs 0", b16.start_o); else pass_n++;
        total_n++; if (b16.overflow_o !== 1'b0) $display("FAIL single_ovf: %b vs 0", b16.overflow_o); else pass_n++;
    endtask

    task automatic test_write_filter();
        int bad = 0;
        b16.valid_i = 1'b1;
        b16.rw_i    = 1'b1;
        b16.data_i  = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b16.start_o !== 1'b0 || b16.fifo_count_o !== 3'd0) bad++;
        end
        b16.valid_i = 1'b0;
        b16.rw_i    = 1'b0;
        total_n++; if (bad != 0) $display("FAIL write_filter: %0d bad cycles vs 0", bad); else pass_n++;
    endtask

    task automatic test_back_to_back();
        bit cont;
        logic [7:0] e;
        fork
            begin
                push16(16'h0001);
                push16(16'h0002);
                push16(16'h0003);
            end
            recv(1'b0, 21, 0, cont);
        join
        for (int i = 0; i < 21 && i < got.size(); i++) begin
            e = (i % 7 == 0) ? 8'h44 : (i % 7 == 5) ? 8'h0D : (i % 7 == 6) ? 8'h0A :
                (i % 7 == 4) ? 8'(8'h31 + i / 7) : 8'h30;
            total_n++; if (got[i] !== e) $display("FAIL b2b_byte%0d: %h vs %h", i, got[i], e); else pass_n++;
        end
        total_n++; if (cont !== 1'b1) $display("FAIL b2b_start_continuous: %b vs 1", cont); else pass_n++;
        total_n++; if (b16.start_o !== 1'b0) $display("FAIL b2b_end_start: %b vs 0", b16.start_o); else pass_n++;
    endtask

    task automatic test_overflow();
        bit cont;
        int extra = 0;
        logic [7:0] e;
        b16.done_i = 1'b0;
        for (int k = 1; k <= 6; k++) push16(16'(k));
        total_n++; if (b16.fifo_count_o !== 3'd4) $display("FAIL ovf_count: %0d vs 4", b16.fifo_count_o); else pass_n++;
        total_n++; if (b16.overflow_o !== 1'b1) $display("FAIL ovf_flag: %b vs 1", b16.overflow_o); else pass_n++;
        recv(1'b0, 35, 0, cont);
        for (int i = 0; i < 35 && i < got.size(); i++) begin
            e = (i % 7 == 0) ? 8'h44 : (i % 7 == 5) ? 8'h0D : (i % 7 == 6) ? 8'h0A :
                (i % 7 == 4) ? 8'(8'h31 + i / 7) : 8'h30;
            total_n++; if (got[i] !== e) $display("FAIL ovf_byte%0d: %h vs %h", i, got[i], e); else pass_n++;
        end
        for (int i = 0; i < 10; i++) begin
            if (b16.start_o !== 1'b0) extra++;
            tick();
        end
        total_n++; if (extra != 0) $display("FAIL ovf_sixth_absent: %0d busy cycles vs 0", extra); else pass_n++;
        total_n++; if (b16.overflow_o !== 1'b1) $display("FAIL ovf_sticky: %b vs 1", b16.overflow_o); else pass_n++;
    endtask

    task automatic test_full_push_pop();
        bit cont;
        logic [7:0] e;
        do_reset();
        b16.done_i = 1'b0;
        for (int k = 1; k <= 5; k++) push16(16'(k));
        total_n++; if (b16.fifo_count_o !== 3'd4) $display("FAIL fpp_full: %0d vs 4", b16.fifo_count_o); else pass_n++;
        b16.done_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        b16.valid_i = 1'b1;
        b16.data_i  = 16'h0006;
        tick();
        b16.valid_i = 1'b0;
        b16.done_i  = 1'b0;
        total_n++; if (b16.fifo_count_o !== 3'd4) $display("FAIL fpp_count: %0d vs 4", b16.fifo_count_o); else pass_n++;
        total_n++; if (b16.overflow_o !== 1'b0) $display("FAIL fpp_ovf: %b vs 0", b16.overflow_o); else pass_n++;
        recv(1'b0, 35, 0, cont);
        for (int i = 0; i < 35 && i < got.size(); i++) begin
            e = (i % 7 == 0) ? 8'h44 : (i % 7 == 5) ? 8'h0D : (i % 7 == 6) ? 8'h0A :
                (i % 7 == 4) ? 8'(8'h32 + i / 7) : 8'h30;
            total_n++; if (got[i] !== e) $display("FAIL fpp_byte%0d: %h vs %h", i, got[i], e); else pass_n++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [7] = '{8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        bit cont;
        b16.done_i = 1'b0;
        push16(16'h1111);
        push16(16'h2222);
        push16(16'h3333);
        total_n++; if (b16.fifo_count_o !== 3'd2) $display("FAIL rmid_queued: %0d vs 2", b16.fifo_count_o); else pass_n++;
        b16.done_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        total_n++; if (b16.start_o !== 1'b0 || b16.fifo_count_o !== 3'd0) $display("FAIL rmid_state: start %b count %0d vs 0 0", b16.start_o, b16.fifo_count_o); else pass_n++;
        total_n++; if (b16.data_o !== 8'h44 || b16.overflow_o !== 1'b0) $display("FAIL rmid_out: data %h ovf %b vs 44 0", b16.data_o, b16.overflow_o); else pass_n++;
        b16.done_i = 1'b0;
        push16(16'hBEEF);
        recv(1'b0, 7, 1, cont);
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            total_n++; if (got[i] !== exp[i]) $display("FAIL rmid_byte%0d: %h vs %h", i, got[i], exp[i]); else pass_n++;
        end
    endtask

    task automatic test_width32();
        logic [7:0] exp [11] = '{8'h44, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        bit cont;
        b32.done_i  = 1'b0;
        b32.valid_i = 1'b1;
        b32.rw_i    = 1'b0;
        b32.data_i  = 32'hDEADBEEF;
        tick();
        b32.valid_i = 1'b0;
        recv(1'b1, 11, 0, cont);
        for (int i = 0; i < 11 && i < got.size(); i++) begin
            total_n++; if (got[i] !== exp[i]) $display("FAIL w32_byte%0d: %h vs %h", i, got[i], exp[i]); else pass_n++;
        end
        total_n++; if (b32.start_o !== 1'b0) $display("FAIL w32_end_start: %b vs 0", b32.start_o); else pass_n++;
    endtask

    initial begin
        b16.valid_i = 1'b0; b16.rw_i = 1'b0; b16.data_i = '0; b16.done_i = 1'b1;
        b32.valid_i = 1'b0; b32.rw_i = 1'b0; b32.data_i = '0; b32.done_i = 1'b1;
        test_reset();
        test_single();
        test_write_filter();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_width32();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
